// File: rtl/dmem_pkg.sv
// Shared types for the CPU data-memory interface: responder FSM states and
// the request record, which the MEM-stage initiator imports as well.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 16;
  localparam int DMEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // The record carries the package widths, so ADDR_W/DATA_W overrides on the
  // responder must be matched by changes here.
  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_wbuf.sv
// Posted-write FIFO for the data-memory responder. Entries are kept in age
// order (slot 0 is the head), so the youngest match is simply the highest
// valid slot whose address matches the lookup.
module dmem_wbuf #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_addr = addr_q[0];
  assign head_data = data_q[0];
  // A pop shifts everything down one slot, so a same-edge push lands one lower.
  assign wr_idx    = pop ? (count_q - 1'b1) : count_q;

  // Occupancy counter; reset discards all buffered entries.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage: shift on pop, then write the pushed entry (later NBA wins).
  // NOTE: storage has no reset; count_q alone defines which slots are valid.
  always_ff @(posedge Clk) begin
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        addr_q[i] <= addr_q[i+1];
        data_q[i] <= data_q[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_idx == CNT_W'(i))) begin
        addr_q[i] <= push_addr;
        data_q[i] <= push_data;
      end
    end
  end

  // Youngest-match lookup: scan oldest to youngest, last hit wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (addr_q[i] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = data_q[i];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory interface: one request at a time over
// valid/ready, serviced against a word array after WAIT_CYCLES extra cycles,
// answered with a one-cycle rsp_valid pulse. Define DMEM_WBUF_EN to compile
// in the posted-write buffer (store posting, load forwarding, idle drain).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int WBUF_DEPTH  = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  dmem_req_t         cap_q;
  dmem_req_t         acc;
  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic                  accept;
  logic                  slow_accept;
  logic                  enter_resp;
  logic                  acc_oor;
  logic                  fast_rsp;
  logic [DATA_W-1:0]     fast_rdata;
  logic                  wbuf_empty;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [DATA_W-1:0]     mem_wdata;

  assign accept = req_valid && req_ready;
  // In IDLE the live request is the one being accepted; afterwards use the copy.
  assign acc     = (state_q == IDLE) ? {req_we, req_addr, req_wdata} : cap_q;
  assign acc_oor = |acc.addr[ADDR_W-1:DEPTH_LOG2];

`ifdef DMEM_WBUF_EN
  logic                  wbuf_full;
  logic                  wbuf_push;
  logic                  wbuf_pop;
  logic                  wbuf_hit;
  logic [DEPTH_LOG2-1:0] wbuf_head_addr;
  logic [DATA_W-1:0]     wbuf_head_data;
  logic [DATA_W-1:0]     wbuf_hit_data;

  assign req_ready  = (state_q == IDLE) && !Rst && !(req_we && wbuf_full);
  assign wbuf_push  = accept && req_we && !acc_oor;
  assign fast_rsp   = wbuf_push || (accept && !req_we && !acc_oor && wbuf_hit);
  assign fast_rdata = req_we ? '0 : wbuf_hit_data;
  // Drain only on idle cycles without an accept, so the array stays single-port.
  assign wbuf_pop   = (state_q == IDLE) && !accept && !wbuf_empty;

  dmem_wbuf #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (DATA_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wbuf (
    .Clk       (Clk),
    .Rst       (Rst),
    .push      (wbuf_push),
    .push_addr (req_addr[DEPTH_LOG2-1:0]),
    .push_data (req_wdata),
    .pop       (wbuf_pop),
    .head_addr (wbuf_head_addr),
    .head_data (wbuf_head_data),
    .full      (wbuf_full),
    .empty     (wbuf_empty),
    .lk_addr   (req_addr[DEPTH_LOG2-1:0]),
    .lk_hit    (wbuf_hit),
    .lk_data   (wbuf_hit_data)
  );

  assign mem_we    = wbuf_pop || (enter_resp && acc.we && !acc_oor);
  assign mem_waddr = wbuf_pop ? wbuf_head_addr : acc.addr[DEPTH_LOG2-1:0];
  assign mem_wdata = wbuf_pop ? wbuf_head_data : acc.wdata;
`else
  assign req_ready  = (state_q == IDLE) && !Rst;
  assign fast_rsp   = 1'b0;
  assign fast_rdata = '0;
  assign wbuf_empty = 1'b1;
  assign mem_we     = enter_resp && acc.we && !acc_oor;
  assign mem_waddr  = acc.addr[DEPTH_LOG2-1:0];
  assign mem_wdata  = acc.wdata;
`endif

  assign slow_accept = accept && !fast_rsp;
  assign busy        = (state_q != IDLE) || !wbuf_empty;

  // Next-state decode and RESP-entry strobe.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (slow_accept) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    enter_resp = (state_d == RESP) && (state_q != RESP);
  end

  // State register, wait counter and captured request.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (slow_accept) begin
        cnt_q <= CNT_LOAD;
        cap_q <= acc;
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Response registers: pulse valid, register load data or zero for stores/errors.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= enter_resp || fast_rsp;
      if (enter_resp) begin
        rsp_err   <= acc_oor;
        rsp_rdata <= (acc.we || acc_oor) ? '0 : mem[acc.addr[DEPTH_LOG2-1:0]];
      end else if (fast_rsp) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= fast_rdata;
      end
    end
  end

  // Word array write port.
  // NOTE: the array is deliberately left out of reset; contents survive Rst.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance driven from
// a vector table plus reset-abort and write-buffer sequences, and a
// WAIT_CYCLES=0 instance for the back-to-back handshake case.
module tb_dmem_responder;

  logic        Clk = 1'b0;
  logic        Rst;

  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;

  logic        req_valid0, req_ready0, req_we0;
  logic [15:0] req_addr0, req_wdata0;
  logic        rsp_valid0, rsp_err0, busy0;
  logic [15:0] rsp_rdata0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  always #5 Clk = ~Clk;

  dmem_responder #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .WAIT_CYCLES(2), .WBUF_DEPTH(4)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .WAIT_CYCLES(0), .WBUF_DEPTH(4)
  ) dut0 (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .busy(busy0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One request on dut: wait for ready, accept, then time and check the response.
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input string name);
    int waited;
    int lat;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    waited    = 0;
    while (!req_ready && waited < 20) begin
      tick();
      waited++;
    end
    check({name, "_ready"}, 32'(waited < 20), 32'd1);
    tick();
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    if (exp_lat > 1) check({name, "_busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, "_lat"},   32'(lat),       32'(exp_lat));
    check({name, "_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
    check({name, "_err"},   32'(rsp_err),   32'(exp_err));
    tick();
    check({name, "_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[16];
    int   waited;
    int   pulses;

    vecs = '{
      '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0},
      '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0},
      '{1'b1, 16'h0000, 16'h5A5A, 16'h0000, 1'b0},
      '{1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1},
      '{1'b1, 16'h0100, 16'h1234, 16'h0000, 1'b1},
      '{1'b0, 16'h0000, 16'h0000, 16'h5A5A, 1'b0},
      '{1'b1, 16'h00FF, 16'hCAFE, 16'h0000, 1'b0},
      '{1'b0, 16'h00FF, 16'h0000, 16'hCAFE, 1'b0},
      '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1},
      '{1'b1, 16'h8000, 16'h7777, 16'h0000, 1'b1},
      '{1'b0, 16'h0000, 16'h0000, 16'h5A5A, 1'b0},
      '{1'b1, 16'h0011, 16'h0F0F, 16'h0000, 1'b0},
      '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0},
      '{1'b0, 16'h0011, 16'h0000, 16'h0F0F, 1'b0},
      '{1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0},
      '{1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0}
    };

    Rst = 1'b1;
    req_valid = 1'b0;  req_we = 1'b0;  req_addr = '0;  req_wdata = '0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
    tick();
    tick();
    check("rst_ready",  32'(req_ready),  32'd0);
    check("rst_valid",  32'(rsp_valid),  32'd0);
    check("rst_rdata",  32'(rsp_rdata),  32'd0);
    check("rst_err",    32'(rsp_err),    32'd0);
    check("rst_busy",   32'(busy),       32'd0);
    check("rst0_ready", 32'(req_ready0), 32'd0);
    check("rst0_busy",  32'(busy0),      32'd0);
    Rst = 1'b0;
    #1;
    check("post_rst_ready",  32'(req_ready),  32'd1);
    check("post_rst_ready0", 32'(req_ready0), 32'd1);

`ifndef DMEM_WBUF_EN
    // Directed table on the WAIT_CYCLES=2 instance: response at N+3.
    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
             vecs[i].exp_err, 3, $sformatf("vec%0d", i));
    end

    // Reset during WAIT of a store to 0x0020 (0x2222 over 0x1111) aborts it.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'h2222;
    check("abort_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("abort_in_wait", 32'(busy), 32'd1);
    Rst = 1'b1;
    #1;
    check("abort_rst_ready", 32'(req_ready), 32'd0);
    check("abort_rst_valid", 32'(rsp_valid), 32'd0);
    check("abort_rst_rdata", 32'(rsp_rdata), 32'd0);
    check("abort_rst_err",   32'(rsp_err),   32'd0);
    check("abort_rst_busy",  32'(busy),      32'd0);
    tick();
    check("abort_rst_valid2", 32'(rsp_valid), 32'd0);
    check("abort_rst_ready2", 32'(req_ready), 32'd0);
    Rst = 1'b0;
    #1;
    check("abort_post_ready", 32'(req_ready), 32'd1);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid) pulses++;
    end
    check("abort_no_rsp", 32'(pulses), 32'd0);
    do_req(1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, 3, "abort_ld_20");

    // WAIT_CYCLES=0 instance, req_valid held high: 4 stores then 4 loads.
    req_valid0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_we0    = (i < 4);
      req_addr0  = 16'h0040 + 16'(i % 4);
      req_wdata0 = (i < 4) ? (16'hA000 + 16'(i)) : 16'h0000;
      waited = 0;
      while (!req_ready0 && waited < 10) begin
        tick();
        waited++;
      end
      check($sformatf("w0_%0d_spacing", i), 32'(waited), (i == 0) ? 32'd0 : 32'd1);
      tick();
      check($sformatf("w0_%0d_valid", i), 32'(rsp_valid0), 32'd1);
      check($sformatf("w0_%0d_ready_in_resp", i), 32'(req_ready0), 32'd0);
      check($sformatf("w0_%0d_rdata", i), 32'(rsp_rdata0),
            (i < 4) ? 32'd0 : (32'hA000 + 32'(i - 4)));
      check($sformatf("w0_%0d_err", i), 32'(rsp_err0), 32'd0);
    end
    req_valid0 = 1'b0;
    tick();
    check("w0_pulse_end", 32'(rsp_valid0), 32'd0);
`else
    // Five back-to-back stores into a 4-entry buffer, req_valid held high.
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_we    = 1'b1;
      req_addr  = 16'h0050 + 16'(i);
      req_wdata = 16'hD000 + 16'(i);
      waited = 0;
      while (!req_ready && waited < 10) begin
        tick();
        waited++;
      end
      check($sformatf("wb_st%0d_wait", i), 32'(waited), (i == 4) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("wb_st%0d_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("wb_st%0d_rdata", i), 32'(rsp_rdata), 32'd0);
      check($sformatf("wb_st%0d_busy", i),  32'(busy),      32'd1);
    end
    req_valid = 1'b0;
    waited = 0;
    while (busy && waited < 20) begin
      tick();
      waited++;
    end
    check("wb_drain_cycles", 32'(waited), 32'd4);
    do_req(1'b0, 16'h0052, 16'h0000, 16'hD002, 1'b0, 3, "wb_ld_52");
    do_req(1'b0, 16'h0054, 16'h0000, 16'hD004, 1'b0, 3, "wb_ld_54");

    // Two stores to 0x0030, then an immediate load forwarded from the youngest.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0030; req_wdata = 16'hAAAA;
    tick();
    req_wdata = 16'hBBBB;
    check("wb_fwd_ready2", 32'(req_ready), 32'd1);
    tick();
    req_we = 1'b0; req_wdata = 16'h0000;
    check("wb_fwd_ready3", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("wb_fwd_valid", 32'(rsp_valid), 32'd1);
    check("wb_fwd_rdata", 32'(rsp_rdata), 32'hBBBB);
    check("wb_fwd_err",   32'(rsp_err),   32'd0);
    waited = 0;
    while (busy && waited < 20) begin
      tick();
      waited++;
    end
    check("wb_fwd_drained", 32'(busy), 32'd0);
    do_req(1'b0, 16'h0030, 16'h0000, 16'hBBBB, 1'b0, 3, "wb_ld_30");
    do_req(1'b1, 16'h0100, 16'h4444, 16'h0000, 1'b1, 3, "wb_st_oor");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the CPU data-memory interface. It accepts one load/store request at a time from the MEM stage over a valid/ready handshake. It services the request against an internal word-addressed array after a programmable wait and returns a single-cycle response pulse. It replaces the fixed-timing data memory so the pipeline can be tested against slow memory, and an optional posted-write buffer can be compiled in.

## Interface
- ADDR_W, 16, request address width (word address)
- DATA_W, 16, data width
- DEPTH_LOG2, 8, array holds 2^DEPTH_LOG2 words
- WAIT_CYCLES, 2, extra cycles before response; 0 is legal
- WBUF_DEPTH, 4, posted-write FIFO entries (used only with DMEM_WBUF_EN)

Ports:
- Clk  in  1  single clock, rising edge
- Rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  DATA_W  load data, 0 for stores or errors
- rsp_err  out  1  address out of range, valid with rsp_valid
- busy  out  1  FSM not IDLE or write buffer non-empty

## Operation
- A request is accepted on a rising edge where req_valid && req_ready. The request fields are captured at that edge. The requester must hold the fields stable while req_valid=1 && req_ready=0.
- FSM states are IDLE, WAIT, and RESP.
  - IDLE: req_ready=1. On accept, go to WAIT, or to RESP if WAIT_CYCLES=0. Load the wait counter with WAIT_CYCLES-1.
  - WAIT: req_ready=0. The counter decrements each cycle. At 0, go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- On entry to RESP, a store writes the array and a load registers the array word into rsp_rdata.
- Range check: if req_addr[ADDR_W-1:DEPTH_LOG2] != 0, then rsp_err=1, rsp_rdata=0, and a store is dropped with the array unchanged. The same timing applies as for a valid access.
- Stores also pulse rsp_valid with rsp_rdata=0 (write acknowledge).
- rsp_rdata holds its value outside rsp_valid. Consumers sample it only with rsp_valid.
- The array is single-port and is not cleared by reset.
- Reset in any state gives: state IDLE, counter 0, req_ready=0 while Rst is high and 1 on the first cycle after, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. An in-flight store is aborted and the array is unchanged. With DMEM_WBUF_EN, the write buffer is emptied and its entries are discarded.

## Timing
- The edge where the request is accepted is cycle N. rsp_valid is high in cycle N+WAIT_CYCLES+1.
- Earliest next accept is the cycle after rsp_valid, so back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- There are no combinational paths from req_* to req_ready or to rsp_*.

## Configuration
- DMEM_WBUF_EN undefined: behaviour is exactly as above.
- DMEM_WBUF_EN defined: a posted-write FIFO of WBUF_DEPTH entries is instantiated.
  - In IDLE, an in-range store is pushed instead of entering WAIT. Its rsp_valid is at N+1 and the FSM stays in IDLE.
  - Out-of-range stores behave as in the unbuffered path.
  - req_ready = !(req_we && fifo_full) in IDLE.
  - Drain: the FIFO head is written to the array on any IDLE cycle with no accept. A new accept has priority over drain. The head pops on the same edge as its array write.
  - A load whose address matches a buffered entry returns the youngest matching data. Its rsp_valid is at N+1 and the FSM stays in IDLE.
  - A load with no match takes the normal WAIT/RESP path. The drain pauses until the FSM returns to IDLE.
  - A simultaneous push and pop on a full FIFO is impossible, because stores are not accepted when the FIFO is full.

## Structure
- A shared package, dmem_pkg, holds the FSM state enum (IDLE/WAIT/RESP) and the request struct (we, addr, wdata). The CPU MEM-stage initiator imports the same struct.
- One sub-module, dmem_wbuf, is the FIFO with a youngest-match lookup port. It is instantiated only under DMEM_WBUF_EN.

## Test plan
- Store addr 0x0010 data 0xBEEF with WAIT_CYCLES=2 -> rsp_valid at N+3 with rsp_rdata=0 and rsp_err=0. A load from 0x0010 then returns 0xBEEF at its N+3.
- Load addr 0x0100 with DEPTH_LOG2=8 -> rsp_err=1 and rsp_rdata=0 at N+3. A store to 0x0100 leaves the array unchanged.
- WAIT_CYCLES=0, with req_valid held high for 4 loads -> each rsp_valid one cycle after its accept, accepts spaced 2 cycles apart, and req_ready low in RESP.
- Assert Rst during WAIT of a store to 0x0020 holding 0x1111 with new data 0x2222 -> all outputs 0 while reset is high, no rsp_valid, and a later load of 0x0020 returns 0x1111.
- DMEM_WBUF_EN with WBUF_DEPTH=4: five back-to-back stores -> the first four are acknowledged at N+1, req_ready drops on the fifth until one drain, and busy=1 until the FIFO is empty.
- DMEM_WBUF_EN: store 0x0030 then 0xAAAA, then store 0x0030 then 0xBBBB, then an immediate load of 0x0030 -> the load returns 0xBBBB at N+1 via forwarding.
